// File: rtl/llr_out_cell_if.sv
// llr_out_cell_if: bus between the LLR output cell, its bank RAM read port
// and the downstream frame serializer.
//   master : the llr_out_cell side (issues RAM reads, presents words)
//   slave  : the environment side (RAM model, phase control, consumer)
interface llr_out_cell_if #(
  parameter int D_WID = 8,
  parameter int A_WID = 8
);
  logic [3:0]       fsm;      // top-level phase, 4'b1000 = output phase
  logic             rate;     // frame length select
  logic [D_WID-1:0] ram_q;    // RAM read data, valid 1 cycle after rd_en
  logic             rd_en;    // RAM read strobe
  logic [A_WID-1:0] rd_addr;  // RAM read address, qualified by rd_en
  logic [D_WID-1:0] dout;     // output word
  logic             sout;     // dout valid
  logic             dready;   // downstream ready
  logic             done;     // end-of-frame pulse

  modport master (
    input  fsm, rate, ram_q, dready,
    output rd_en, rd_addr, dout, sout, done
  );

  modport slave (
    output fsm, rate, ram_q, dready,
    input  rd_en, rd_addr, dout, sout, done
  );
endinterface

// File: rtl/llr_out_cell.sv
// llr_out_cell: drains one variable-node RAM bank in address order after
// decoding and streams the words out over a valid/ready interface. A 2-entry
// buffer absorbs the 1-cycle RAM read latency so downstream backpressure never
// loses a word and dready never reaches dout/sout combinationally.
//
// Optional build macro: LLR_OUT_HARD_DEC_EN
//   defined   - each buffered word is reduced to its hard decision
//               (dout[0] = LLR sign bit, upper bits 0)
//   undefined - dout carries the full LLR unchanged
module llr_out_cell #(
  parameter int D_WID     = 8,
  parameter int A_WID     = 8,
  parameter int BASE_ADDR = 0,
  parameter int LEN_R0    = 128,
  parameter int LEN_R1    = 192
) (
  input  logic            clk,
  input  logic            reset_n,
  llr_out_cell_if.master  bus
);

  // Counters need one extra bit: a frame may span the whole address space.
  localparam int          CW        = A_WID + 1;
  localparam logic [3:0]  OUT_PHASE = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_WAIT
  } state_t;

  state_t           state, state_nxt;

  logic [CW-1:0]    len;
  logic [CW-1:0]    rd_cnt;
  logic [CW-1:0]    tx_cnt;
  logic             inflight;

  logic [D_WID-1:0] buf_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  logic             in_phase;
  logic             start;
  logic             abort;
  logic             sout;
  logic             xfer;
  logic             last_xfer;
  logic             rd_en;
  logic             push;
  logic [2:0]       credit_used;
  logic [A_WID-1:0] addr_sum;
  logic [D_WID-1:0] store_word;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign in_phase  = (bus.fsm == OUT_PHASE);
  assign start     = (state == S_IDLE) && in_phase;
  assign abort     = (state == S_RUN) && !in_phase;
  assign sout      = (occ != 2'd0);
  assign xfer      = sout && bus.dready;
  assign last_xfer = (state == S_RUN) && xfer && (tx_cnt == len - CW'(1));

  // Buffer slots already spoken for: stored words plus the read in flight.
  assign credit_used = 3'(occ) + 3'(inflight);

  // A transfer this cycle frees a slot at the same edge the new read is
  // issued, so counting it as credit keeps back-to-back reads going at
  // 1 word/cycle while still never exceeding two buffered words.
  assign rd_en = (state == S_RUN) && (rd_cnt < len) &&
                 ((credit_used < 3'd2) || xfer);

  // Data returning after an abort belongs to a dead frame and is dropped.
  assign push = inflight && (state == S_RUN) && !abort;

  assign addr_sum = A_WID'(BASE_ADDR) + rd_cnt[A_WID-1:0];

`ifdef LLR_OUT_HARD_DEC_EN
  // Hard decision: negative LLR (sign bit set) decodes to bit 1.
  assign store_word = {{(D_WID-1){1'b0}}, bus.ram_q[D_WID-1]};
`else
  assign store_word = bus.ram_q;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state decode
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_phase) state_nxt = S_RUN;
      S_RUN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_xfer) state_nxt = S_FIN;
      end
      S_FIN:  state_nxt = S_WAIT;
      S_WAIT: if (!in_phase) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame length latch and read/transfer counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len    <= '0;
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else if (start) begin
      len    <= bus.rate ? CW'(LEN_R1) : CW'(LEN_R0);
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else if (state == S_RUN) begin
      if (rd_en) rd_cnt <= rd_cnt + CW'(1);
      if (xfer)  tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // RAM read latency tracker; an abort discards the outstanding read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= rd_en && !abort;
  end

  // Buffer occupancy and pointers; flushed whenever no frame is running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if ((state != S_RUN) || abort) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (xfer) rd_ptr <= ~rd_ptr;
      case ({push, xfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage write
  // NOTE: the data slots carry no reset; they are only observed through dout,
  // which is forced to 0 whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= store_word;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_en ? addr_sum : '0;
  assign bus.sout    = sout;
  assign bus.dout    = sout ? buf_mem[rd_ptr] : '0;
  assign bus.done    = (state == S_FIN);

  // The read-issue credit rule must make overflow impossible.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(push && !xfer && (occ == 2'd2)));

endmodule

// File: tb/tb_llr_out_cell.sv
// tb_llr_out_cell: directed bench for llr_out_cell. Two instances share the
// clock and reset: dut_a uses the default geometry (base 0, 128/192 words),
// dut_b uses base 16 and a 4-word rate-0 frame. Only the selected instance
// sees the output phase; the other is held idle.
module tb_llr_out_cell;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  llr_out_cell_if #(.D_WID(8), .A_WID(8)) if_a ();
  llr_out_cell_if #(.D_WID(8), .A_WID(8)) if_b ();

  llr_out_cell #(.D_WID(8), .A_WID(8), .BASE_ADDR(0), .LEN_R0(128), .LEN_R1(192))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  llr_out_cell #(.D_WID(8), .A_WID(8), .BASE_ADDR(16), .LEN_R0(4), .LEN_R1(192))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

  // Stimulus routing to the selected instance
  logic       sel = 1'b0;
  logic [3:0] fsm_v = 4'd0;
  logic       rate_v = 1'b0;
  logic       dready_v = 1'b0;

  assign if_a.fsm    = sel ? 4'd0 : fsm_v;
  assign if_a.rate   = rate_v;
  assign if_a.dready = sel ? 1'b0 : dready_v;
  assign if_b.fsm    = sel ? fsm_v : 4'd0;
  assign if_b.rate   = rate_v;
  assign if_b.dready = sel ? dready_v : 1'b0;

  logic       c_sout, c_rd_en, c_done;
  logic [7:0] c_dout, c_rd_addr;
  assign c_sout    = sel ? if_b.sout    : if_a.sout;
  assign c_rd_en   = sel ? if_b.rd_en   : if_a.rd_en;
  assign c_done    = sel ? if_b.done    : if_a.done;
  assign c_dout    = sel ? if_b.dout    : if_a.dout;
  assign c_rd_addr = sel ? if_b.rd_addr : if_a.rd_addr;

  // RAM models with 1-cycle read latency
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (if_a.rd_en) if_a.ram_q <= mem_a[if_a.rd_addr];
    if (if_b.rd_en) if_b.ram_q <= mem_b[if_b.rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word k of a frame, including the optional hard decision
  function automatic logic [7:0] exp_word(input logic s, input int k);
    logic [7:0] raw;
    logic [7:0] b_tbl [4];
    b_tbl[0] = 8'h80; b_tbl[1] = 8'h7F; b_tbl[2] = 8'h01; b_tbl[3] = 8'hFF;
    raw = s ? b_tbl[k % 4] : 8'(k);
`ifdef LLR_OUT_HARD_DEC_EN
    return {7'd0, raw[7]};
`else
    return raw;
`endif
  endfunction

  // One full frame on the selected instance with per-cycle checking
  task automatic run_frame(input logic s, input logic r, input logic stall, input int exp_len);
    int n_tx = 0, n_rd = 0, first_rd = -1, first_sout = -1, done_cnt = 0, post = 0;
    int base;
    logic prev_stall = 1'b0;
    logic [7:0] prev_dout = 8'd0;
    base = s ? 16 : 0;
    @(negedge clk);
    sel = s; rate_v = r; fsm_v = 4'b1000; dready_v = 1'b1;
    for (int cyc = 0; cyc < exp_len * 4 + 40; cyc++) begin
      @(negedge clk);
      dready_v = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == 5) rate_v = ~r;  // must not affect the running frame
      #1;
      if (c_rd_en) begin
        check("rd_addr", 32'(c_rd_addr), 32'(base + n_rd));
        check("rd_within_len", 32'(n_rd < exp_len), 32'd1);
        if (first_rd < 0) first_rd = cyc;
        n_rd++;
      end
      if (c_sout && first_sout < 0) begin
        first_sout = cyc;
        check("first_sout_latency", 32'(cyc - first_rd), 32'd2);
      end
      if (prev_stall) begin
        check("stall_sout_held", 32'(c_sout), 32'd1);
        check("stall_dout_stable", 32'(c_dout), 32'(prev_dout));
      end
      if (n_tx == exp_len)
        check("no_extra_word", 32'(c_sout), 32'd0);
      else if (!stall && first_sout >= 0)
        check("back_to_back", 32'(c_sout), 32'd1);
      if (c_sout && dready_v) begin
        check("dout", 32'(c_dout), 32'(exp_word(s, n_tx)));
        n_tx++;
      end
      if (c_done) begin
        check("done_after_last", 32'(n_tx), 32'(exp_len));
        done_cnt++;
      end
      prev_stall = c_sout && !dready_v;
      prev_dout  = c_dout;
      if (done_cnt > 0) post++;
      if (post > 3) break;
    end
    check("frame_tx_count", 32'(n_tx), 32'(exp_len));
    check("frame_rd_count", 32'(n_rd), 32'(exp_len));
    check("done_pulses", 32'(done_cnt), 32'd1);
    fsm_v = 4'd0; dready_v = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic s;
    logic r;
    logic stall;
    int   len;
  } scen_t;

  scen_t tbl [4];

  initial begin
    int n;
    tbl[0] = '{s: 1'b0, r: 1'b0, stall: 1'b0, len: 128};  // full-rate frame
    tbl[1] = '{s: 1'b0, r: 1'b1, stall: 1'b1, len: 192};  // backpressure 1,0,0,1
    tbl[2] = '{s: 1'b1, r: 1'b0, stall: 1'b0, len: 4};    // base 16, 4 words
    tbl[3] = '{s: 1'b1, r: 1'b0, stall: 1'b1, len: 4};    // same with stalls

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'h55;
    end
    mem_b[16] = 8'h80; mem_b[17] = 8'h7F; mem_b[18] = 8'h01; mem_b[19] = 8'hFF;

    // Reset state
    #12;
    check("rst_sout", 32'(if_a.sout), 32'd0);
    check("rst_rd_en", 32'(if_a.rd_en), 32'd0);
    check("rst_done", 32'(if_a.done), 32'd0);
    check("rst_dout", 32'(if_a.dout), 32'd0);
    check("rst_rd_addr_b", 32'(if_b.rd_addr), 32'd0);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_sout", 32'(if_a.sout), 32'd0);
    check("idle_rd_en", 32'(if_b.rd_en), 32'd0);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].s, tbl[i].r, tbl[i].stall, tbl[i].len);

    // Abort after 10 transfers
    sel = 1'b0; rate_v = 1'b0; fsm_v = 4'b1000; dready_v = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      @(negedge clk); #1;
      if (c_sout && dready_v) n++;
    end
    check("abort_reached_10", 32'(n), 32'd10);
    @(negedge clk);
    fsm_v = 4'd0; dready_v = 1'b0;
    @(negedge clk); #1;
    check("abort_sout", 32'(c_sout), 32'd0);
    check("abort_done", 32'(c_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("abort_no_done", 32'(c_done), 32'd0);
      check("abort_no_rd", 32'(c_rd_en), 32'd0);
    end
    run_frame(1'b0, 1'b0, 1'b0, 128);  // restarts at address 0

    // Asynchronous reset mid-frame with a word presented
    sel = 1'b0; rate_v = 1'b0; fsm_v = 4'b1000; dready_v = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); #1;
      if (n >= 3 && c_sout) break;
      if (c_sout && dready_v) n++;
    end
    check("rst_mid_sout_pre", 32'(c_sout), 32'd1);
    check("rst_mid_dout_pre", 32'(c_dout), 32'(exp_word(1'b0, 3)));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_sout", 32'(if_a.sout), 32'd0);
    check("rst_mid_dout", 32'(if_a.dout), 32'd0);
    check("rst_mid_rd_en", 32'(if_a.rd_en), 32'd0);
    check("rst_mid_rd_addr", 32'(if_a.rd_addr), 32'd0);
    check("rst_mid_done", 32'(if_a.done), 32'd0);
    fsm_v = 4'd0; dready_v = 1'b0;
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_sout", 32'(c_sout), 32'd0);
    check("post_rst_rd_en", 32'(c_rd_en), 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 128);  // full frame from address 0 again

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
